// File: rtl/mfp_ahb_move_fifo_pkg.sv
// Shared constants for the AHB move FIFO: bus addresses, register map,
// move-code fields and the address-phase bundle.
package mfp_ahb_move_fifo_pkg;

  localparam logic [31:0] H_MVF_MOVE   = 32'h1f90_0000;
  localparam logic [31:0] H_MVF_STATUS = 32'h1f90_0004;
  localparam logic [31:0] H_MVF_CTRL   = 32'h1f90_0008;
  localparam logic [31:0] H_MVF_EXEC   = 32'h1f90_000C;

  typedef enum logic [1:0] {
    REG_MOVE   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_EXEC   = 2'd3
  } reg_sel_e;

  localparam int MV_FACE_LSB = 2;
  localparam int MV_FACE_W   = 3;
  localparam int MV_TURN_LSB = 0;
  localparam int MV_TURN_W   = 2;

  localparam logic [1:0] TURN_CW  = 2'd1;
  localparam logic [1:0] TURN_CCW = 2'd2;
  localparam logic [1:0] TURN_180 = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IE      = 2;

  typedef struct packed {
    logic     vld;
    logic     wr;
    reg_sel_e sel;
  } ahb_ap_t;

  function automatic logic [4:0] mv_code(
    input logic [MV_FACE_W-1:0] face,
    input logic [MV_TURN_W-1:0] turn
  );
    return {face, turn};
  endfunction

endpackage

// File: rtl/mfp_ahb_move_fifo_if.sv
// AHB-lite slave signals plus the move stream to the rotation engine.
interface mfp_ahb_move_fifo_if #(
  parameter int MOVE_W = 5
);

  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [31:0]       HWDATA;
  logic              HWRITE;
  logic              HSEL;
  logic [31:0]       HRDATA;
  logic [MOVE_W-1:0] MV_DATA;
  logic              MV_VALID;
  logic              MV_READY;
  logic              IRQ_EMPTY;

  modport slave (
    input  HADDR, HTRANS, HWDATA, HWRITE, HSEL,
    input  MV_READY,
    output HRDATA, MV_DATA, MV_VALID, IRQ_EMPTY
  );

  modport master (
    output HADDR, HTRANS, HWDATA, HWRITE, HSEL,
    output MV_READY,
    input  HRDATA, MV_DATA, MV_VALID, IRQ_EMPTY
  );

endinterface

// File: rtl/mfp_move_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy outputs.
// Also exposes the entry behind the head for look-ahead reads.
module mfp_move_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign rd_ptr_n = rd_ptr + AW'(1);

  // flush beats both ports; a full FIFO still accepts when it pops
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_n;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = empty ? '0 : mem[rd_ptr];
  assign next = mem[rd_ptr_n];

endmodule

// File: rtl/mfp_ahb_move_fifo.sv
// AHB-lite wrapper around the move FIFO: address-phase capture,
// CTRL/EXEC/overflow registers and registered read data.
module mfp_ahb_move_fifo
  import mfp_ahb_move_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int MOVE_W = 5
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  mfp_ahb_move_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ahb_ap_t           ap;
  logic              ap_hit;
  reg_sel_e          rsel;
  logic              wr_move;
  logic              wr_ctrl;
  logic              wr_exec;
  logic              flush;
  logic              pop;

  logic [MOVE_W-1:0] f_head;
  logic [MOVE_W-1:0] f_next;
  logic [CW-1:0]     f_count;
  logic              f_full;
  logic              f_empty;

  logic              ovf;
  logic              ie;
  logic              irq;
  logic [15:0]       exec_cnt;
  logic [31:0]       hrdata;

  logic [CW-1:0]     cnt_rd;
  logic [MOVE_W-1:0] head_rd;
  logic [15:0]       exec_rd;
  logic [31:0]       rd_nxt;
  logic              unused_ok;

  assign ap_hit = bus.HSEL & bus.HTRANS[1];
  assign rsel   = reg_sel_e'(bus.HADDR[3:2]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap <= '0;
    end else begin
      ap.vld <= ap_hit;
      ap.wr  <= bus.HWRITE;
      ap.sel <= rsel;
    end
  end

  assign wr_move = ap.vld & ap.wr & (ap.sel == REG_MOVE);
  assign wr_ctrl = ap.vld & ap.wr & (ap.sel == REG_CTRL);
  assign wr_exec = ap.vld & ap.wr & (ap.sel == REG_EXEC);
  assign flush   = wr_ctrl & bus.HWDATA[CTRL_FLUSH];
  assign pop     = ~f_empty & bus.MV_READY & ~flush;

  mfp_move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MOVE_W)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (wr_move),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.HWDATA[MOVE_W-1:0]),
    .head  (f_head),
    .next  (f_next),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf      <= 1'b0;
      ie       <= 1'b0;
      irq      <= 1'b0;
      exec_cnt <= '0;
    end else begin
      if (wr_move & f_full & ~pop)
        ovf <= 1'b1;
      else if (wr_ctrl & bus.HWDATA[CTRL_CLR_OVF])
        ovf <= 1'b0;
      if (wr_ctrl)
        ie <= bus.HWDATA[CTRL_IE];
      if (wr_exec)
        exec_cnt <= '0;
      else if (pop)
        exec_cnt <= exec_cnt + 16'd1;
      irq <= f_empty & ie;
    end
  end

  // read view: this cycle's pop applied, the pending data-phase write not yet
  assign cnt_rd  = f_count - CW'(pop);
  assign head_rd = (cnt_rd == '0) ? '0 : (pop ? f_next : f_head);
  assign exec_rd = exec_cnt + 16'(pop);

  always_comb begin
    rd_nxt = '0;
    unique case (rsel)
      REG_MOVE: rd_nxt = 32'(head_rd);
      REG_STATUS: begin
        rd_nxt[ST_EMPTY]          = (cnt_rd == '0);
        rd_nxt[ST_FULL]           = (cnt_rd == CW'(DEPTH));
        rd_nxt[ST_OVF]            = ovf;
        rd_nxt[ST_CNT_LSB +: 8]   = 8'(cnt_rd);
      end
      REG_CTRL: rd_nxt[CTRL_IE]  = ie;
      REG_EXEC: rd_nxt[15:0]     = exec_rd;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      hrdata <= '0;
    else if (ap_hit & ~bus.HWRITE)
      hrdata <= rd_nxt;
  end

  assign bus.HRDATA    = hrdata;
  assign bus.MV_DATA   = f_head;
  assign bus.MV_VALID  = ~f_empty;
  assign bus.IRQ_EMPTY = irq;

  assign unused_ok = ^{bus.HADDR[31:4], bus.HADDR[1:0],
                       bus.HTRANS[0], bus.HWDATA[31:MOVE_W]};

endmodule

// File: tb/tb_mfp_ahb_move_fifo.sv
// Bench for mfp_ahb_move_fifo: queue-based reference model checked every
// cycle, plus directed bus sequences with literal expectations.
module tb_mfp_ahb_move_fifo;
  import mfp_ahb_move_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   total = 0;
  int   bad = 0;

  mfp_ahb_move_fifo_if #(.MOVE_W(5)) bus();

  mfp_ahb_move_fifo #(
    .DEPTH  (DEPTH),
    .MOVE_W (5)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endfunction

  // reference model: queue of moves, bus pipeline of one stage
  int          q[$];
  bit          m_ovf, m_ie, m_av, m_aw, rd_dp, exp_irq;
  logic [1:0]  m_aa;
  logic [15:0] m_exec;
  logic [31:0] exp_rd;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      q.delete();
      m_ovf = 0; m_ie = 0; m_av = 0; m_aw = 0; m_aa = 0;
      rd_dp = 0; exp_irq = 0; m_exec = 0; exp_rd = 0;
    end else begin : step
      bit          fl, irq_n, pop;
      logic [31:0] v;
      fl    = m_av && m_aw && m_aa == 2'd2 && bus.HWDATA[0];
      irq_n = (q.size() == 0) && m_ie;
      pop   = !fl && q.size() > 0 && bus.MV_READY;
      if (pop) begin
        void'(q.pop_front());
        m_exec = m_exec + 16'd1;
      end
      rd_dp = 0;
      if (bus.HSEL && bus.HTRANS[1] && !bus.HWRITE) begin
        rd_dp = 1;
        v = 0;
        case (bus.HADDR[3:2])
          2'd0: v = (q.size() > 0) ? 32'(q[0]) : 0;
          2'd1: begin
            v[15:8] = 8'(q.size());
            v[2] = m_ovf;
            v[1] = (q.size() == DEPTH);
            v[0] = (q.size() == 0);
          end
          2'd2: v[2] = m_ie;
          default: v[15:0] = m_exec;
        endcase
        exp_rd = v;
      end
      if (m_av && m_aw) begin
        case (m_aa)
          2'd0: if (q.size() < DEPTH) q.push_back(int'(bus.HWDATA[4:0]));
                else m_ovf = 1;
          2'd2: begin
            if (bus.HWDATA[0]) q.delete();
            if (bus.HWDATA[1]) m_ovf = 0;
            m_ie = bus.HWDATA[2];
          end
          2'd3: m_exec = 0;
          default: ;
        endcase
      end
      m_av = bus.HSEL && bus.HTRANS[1];
      m_aw = bus.HWRITE;
      m_aa = bus.HADDR[3:2];
      exp_irq = irq_n;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("m_valid", 32'(bus.MV_VALID), 32'(q.size() != 0));
      chk("m_data", 32'(bus.MV_DATA), (q.size() > 0) ? 32'(q[0]) : 0);
      chk("m_irq", 32'(bus.IRQ_EMPTY), 32'(exp_irq));
      if (rd_dp) chk("m_hrdata", bus.HRDATA, exp_rd);
    end
  end

  task automatic idle();
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWRITE = 0;
  endtask

  task automatic addr(input logic [31:0] a, input logic w);
    bus.HSEL = 1; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HADDR = a;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr(a, 1'b1);
    @(negedge HCLK);
    idle();
    bus.HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic rd_chk(input string n, input logic [31:0] a,
                        input logic [31:0] e);
    addr(a, 1'b0);
    @(negedge HCLK);
    idle();
    chk(n, bus.HRDATA, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e;
    idle();
    bus.HADDR = 0; bus.HWDATA = 0; bus.MV_READY = 0;
    repeat (3) @(negedge HCLK);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_mvdata", 32'(bus.MV_DATA), 0);
    chk("rst_valid", 32'(bus.MV_VALID), 0);
    chk("rst_irq", 32'(bus.IRQ_EMPTY), 0);
    HRESETn = 1;
    @(negedge HCLK);

    // three moves, last one followed back-to-back by a STATUS read
    wr(H_MVF_MOVE, 32'(mv_code(3'd2, TURN_CW)));
    wr(H_MVF_MOVE, 32'(mv_code(3'd4, TURN_CCW)));
    addr(H_MVF_MOVE, 1'b1);
    @(negedge HCLK);
    addr(H_MVF_STATUS, 1'b0);
    bus.HWDATA = 32'h1F;
    @(negedge HCLK);
    idle();
    chk("status_b2b", bus.HRDATA, 32'h0200);
    rd_chk("status3", H_MVF_STATUS, 32'h0300);
    chk("valid3", 32'(bus.MV_VALID), 1);
    chk("head3", 32'(bus.MV_DATA), 32'h09);
    rd_chk("move_peek", H_MVF_MOVE, 32'h09);
    rd_chk("status_peek", H_MVF_STATUS, 32'h0300);

    // enable IRQ, drain three
    wr(H_MVF_CTRL, 32'h4);
    bus.MV_READY = 1;
    for (int i = 0; i < 3; i++) begin
      e = (i == 0) ? 32'h09 : (i == 1) ? 32'h12 : 32'h1F;
      chk("drain_a", 32'(bus.MV_DATA), e);
      @(negedge HCLK);
    end
    bus.MV_READY = 0;
    chk("valid_a", 32'(bus.MV_VALID), 0);
    rd_chk("exec3", H_MVF_EXEC, 32'd3);
    chk("irq_set", 32'(bus.IRQ_EMPTY), 1);
    rd_chk("status_empty", H_MVF_STATUS, 32'h0001);

    // 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) wr(H_MVF_MOVE, 32'(i));
    rd_chk("status_ovf", H_MVF_STATUS, 32'h1006);
    wr(H_MVF_CTRL, 32'h2);
    rd_chk("status_clr", H_MVF_STATUS, 32'h1002);
    chk("irq_off", 32'(bus.IRQ_EMPTY), 0);

    // push while full with a same-cycle pop
    addr(H_MVF_MOVE, 1'b1);
    @(negedge HCLK);
    idle();
    bus.HWDATA = 32'h07;
    bus.MV_READY = 1;
    @(negedge HCLK);
    bus.MV_READY = 0;
    rd_chk("status_pp", H_MVF_STATUS, 32'h1002);
    bus.MV_READY = 1;
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 32'(i + 2) : 32'h07;
      chk("drain_b", 32'(bus.MV_DATA), e);
      @(negedge HCLK);
    end
    bus.MV_READY = 0;
    chk("valid_b", 32'(bus.MV_VALID), 0);
    rd_chk("exec20", H_MVF_EXEC, 32'd20);

    // flush of 8 entries against a same-cycle pop
    for (int i = 1; i <= 8; i++) wr(H_MVF_MOVE, 32'(i));
    addr(H_MVF_CTRL, 1'b1);
    @(negedge HCLK);
    idle();
    bus.HWDATA = 32'h1;
    bus.MV_READY = 1;
    @(negedge HCLK);
    bus.MV_READY = 0;
    chk("flush_valid", 32'(bus.MV_VALID), 0);
    rd_chk("exec_flush", H_MVF_EXEC, 32'd20);
    rd_chk("status_flush", H_MVF_STATUS, 32'h0001);

    // EXEC clear, then a pipelined burst at one move per cycle
    wr(H_MVF_EXEC, 32'hDEAD);
    rd_chk("exec_clr", H_MVF_EXEC, 32'd0);
    bus.MV_READY = 1;
    for (int i = 0; i < 6; i++) begin
      addr(H_MVF_MOVE, 1'b1);
      if (i > 0) bus.HWDATA = 32'(32'h10 + i - 1);
      @(negedge HCLK);
    end
    idle();
    bus.HWDATA = 32'h15;
    @(negedge HCLK);
    repeat (2) @(negedge HCLK);
    bus.MV_READY = 0;
    rd_chk("exec_burst", H_MVF_EXEC, 32'd6);
    rd_chk("status_burst", H_MVF_STATUS, 32'h0001);
    rd_chk("ctrl_ie0", H_MVF_CTRL, 32'h0);
    wr(H_MVF_CTRL, 32'h4);
    rd_chk("ctrl_ie1", H_MVF_CTRL, 32'h4);
    chk("irq_ie1", 32'(bus.IRQ_EMPTY), 1);

    // reset during a MOVE data phase
    wr(H_MVF_MOVE, 32'h03);
    wr(H_MVF_MOVE, 32'h04);
    addr(H_MVF_MOVE, 1'b1);
    @(negedge HCLK);
    idle();
    bus.HWDATA = 32'h05;
    #2 HRESETn = 0;
    @(negedge HCLK);
    chk("rst2_hrdata", bus.HRDATA, 0);
    chk("rst2_mvdata", 32'(bus.MV_DATA), 0);
    chk("rst2_valid", 32'(bus.MV_VALID), 0);
    chk("rst2_irq", 32'(bus.IRQ_EMPTY), 0);
    @(negedge HCLK);
    HRESETn = 1;
    @(negedge HCLK);
    rd_chk("status_rst", H_MVF_STATUS, 32'h0001);
    rd_chk("ctrl_rst", H_MVF_CTRL, 32'h0);
    rd_chk("exec_rst", H_MVF_EXEC, 32'h0);
    @(negedge HCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_move_fifo.md
# mfp_ahb_move_fifo

Memory-mapped AHB-lite slave that buffers cube move codes written by the MIPS core and hands them, one per handshake, to the downstream cube rotation engine. It sits on the system AHB bus next to the cube peripheral. The bus decoder drives its select line, and its read data returns through the bus read mux in the data phase. It decouples software move generation from the multi-cycle face-rotation datapath and reports fill and overflow status back to software.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64
- MOVE_W, 5, move code width: [4:2] face 0–5, [1:0] turn 1=CW, 2=CCW, 3=180

Ports:
- HCLK  in  1  system clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  32  bus address; only [3:2] used by this block
- HTRANS  in  2  transfer type; transfer valid when HTRANS[1]=1
- HWDATA  in  32  write data, valid in the data phase
- HWRITE  in  1  1=write
- HSEL  in  1  slave select from the bus decoder, address phase
- HRDATA  out  32  read data, valid in the data phase
- MV_DATA  out  MOVE_W  head-of-FIFO move code
- MV_VALID  out  1  FIFO non-empty
- MV_READY  in  1  rotation engine accepts MV_DATA this cycle
- IRQ_EMPTY  out  1  level: FIFO empty AND IE bit set

## Operation
- Address phase is captured when HSEL & HTRANS[1]: register addr[3:2] and HWRITE.
- The action executes on the following cycle (data phase) using HWDATA.
- Register map (word offsets):
  - 0x0 MOVE. W: push HWDATA[MOVE_W-1:0]. R: head entry, zero-extended; 0 when empty; a read does not pop.
  - 0x4 STATUS. R: [0] empty, [1] full, [2] overflow (sticky), [15:8] count. W: ignored.
  - 0x8 CTRL. W: [0] flush (self-clearing), [1] clear overflow, [2] IE. R: {29'b0, IE, 2'b0}.
  - 0xC EXEC. R: 16-bit count of popped moves, wraps 0xFFFF→0. W: any value clears it to 0.
- Pop occurs when MV_VALID & MV_READY; EXEC increments on each pop.
- Push while full with no same-cycle pop: data is dropped, overflow is set, count is unchanged.
- Push while full with a same-cycle pop: accepted; count stays DEPTH.
- Push while empty with MV_READY high: no bypass; the entry is written and becomes visible next cycle.
- Flush: count=0 and pointers=0. Flush wins over a same-cycle pop; that pop neither completes nor increments EXEC. Overflow and IE are unaffected.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset values:
  - HRDATA=0, MV_DATA=0, MV_VALID=0, IRQ_EMPTY=0
  - count=0, pointers=0, overflow=0, IE=0, EXEC=0
- Reset asserted mid-transfer aborts the pending data phase; no write takes effect.

## Timing
- Write: address phase cycle N, data phase N+1, storage updated at the end of N+1. MV_VALID rises in N+2 when the FIFO was empty.
- Read: HRDATA is registered at the edge ending address phase N and holds during data phase N+1. It reflects state after all updates of cycle N, including a pop in cycle N.
- Back-to-back transfers: a new address phase overlaps the prior data phase. A read of STATUS immediately after a MOVE write returns the pre-push count (the push is not yet visible); the next read shows it.
- MV_DATA and MV_VALID are registered or come straight from storage and count, with no combinational path from the MV_READY input.
- One push and one pop may both occur every cycle; sustained throughput is 1 move/cycle.
- IRQ_EMPTY is registered and updates the cycle after empty or IE changes.

## Structure
- Register offsets go in the shared constants header, beside the existing peripheral addresses: H_MVF_MOVE, H_MVF_STATUS, H_MVF_CTRL, H_MVF_EXEC at 0x1f900000/4/8/C. The decoder gains one HSEL bit and the read mux gains one input.
- Move-code field positions and turn encodings also go in that header.
- Sub-module mfp_move_fifo: generic synchronous FIFO with push/pop/flush, full/empty/count outputs, and parameters DEPTH and WIDTH.
- The wrapper holds address-phase registers, CTRL/EXEC/overflow registers and read-data mux.

## Test plan
- Reset with MV_READY=0, then write MOVE=0x09, 0x12, 0x1F → STATUS=0x0300, MV_VALID=1, MV_DATA=0x09. A MOVE read returns 0x09 and count stays 3.
- Pulse MV_READY for 3 cycles → MV_DATA sequence 0x09, 0x12, 0x1F, then MV_VALID=0, EXEC=3, STATUS=0x0001, IRQ_EMPTY=1 once IE is set.
- With MV_READY=0, 17 pushes of 0x01..0x11 at DEPTH=16 → STATUS=0x1006 (count 16, full, overflow). 0x11 is dropped. Drain order is 0x01..0x10. Write CTRL=0x2 → overflow=0.
- FIFO full, push 0x07 in the same cycle as a pop → count stays 16, overflow stays 0, 0x07 is the last entry drained.
- 8 entries, flush written on a cycle with MV_READY=1 → count=0, EXEC unchanged, MV_VALID=0 next cycle.
- Assert HRESETn low mid-write data phase (MOVE=0x05) → FIFO empty, all outputs 0, and a subsequent STATUS read=0x0001.
